sram_ctrl: RTL and testbench

Single-port initiator for the 128 x 32 OpenRAM macro (`sram`): accepts word read/write requests on a valid/ready request channel, drives the macro's `csb0/web0/addr0/din0` pins, captures `dout0`, and returns responses on a valid/ready response channel. Byte-masked stores are implemented as read-modify-write, because the macro has no byte enables. It sits between the core's data-memory port and the macro instance; one request is outstanding at a time.

---
 rtl/sram_ctrl_pkg.sv | 26 ++
 rtl/sram_byte_merge.sv | 17 +
 rtl/sram_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types, widths and helpers for the OpenRAM 128x32 initiator.
// The merge helper is also used by the instruction-side fill path.
package sram_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 7;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_DATA  = 3'd1,
        RMW_DATA = 3'd2,
        RMW_WR   = 3'd3,
        RESP     = 3'd4
    } sram_ctrl_state_e;

    function automatic logic [DATA_WIDTH-1:0] mask_to_bits(input logic [MASK_WIDTH-1:0] mask);
        logic [DATA_WIDTH-1:0] bits;
        bits = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < MASK_WIDTH; i++) begin
            bits[i*8 +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/sram_byte_merge.sv
// Combinational byte-lane merge: bytes selected by mask come from new_word,
// the rest keep old_word.
module sram_byte_merge
    import sram_ctrl_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] new_word,
    input  logic [MASK_WIDTH-1:0] mask,
    output logic [DATA_WIDTH-1:0] merged
);

    logic [DATA_WIDTH-1:0] bitmask_s;

    assign bitmask_s = mask_to_bits(mask);
    assign merged    = (old_word & ~bitmask_s) | (new_word & bitmask_s);

endmodule

// File: rtl/sram_ctrl.sv
// Single-outstanding initiator for the OpenRAM macro; partial-mask stores
// are done as read-modify-write since the macro has no byte enables.
module sram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [MASK_WIDTH-1:0] req_mask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);
    import sram_ctrl_pkg::*;

    sram_ctrl_state_e      state_r, next_s;
    logic                  accept_s;
    logic                  mask_full_s, mask_none_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [MASK_WIDTH-1:0] mask_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] merged_s, merged_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  rsp_valid_r;

    assign mask_full_s = &req_mask;
    assign mask_none_s = ~|req_mask;
    assign req_ready   = (state_r == IDLE);
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rdata_r;

    sram_byte_merge u_merge (
        .old_word (dout0),
        .new_word (wdata_r),
        .mask     (mask_r),
        .merged   (merged_s)
    );

    // Next-state and macro pin decode; pins idle whenever reset is asserted.
    always_comb begin
        next_s   = state_r;
        accept_s = 1'b0;
        csb0     = 1'b1;
        web0     = 1'b1;
        addr0    = {ADDR_WIDTH{1'b0}};
        din0     = {DATA_WIDTH{1'b0}};
        if (!rst_n) begin
            next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        accept_s = 1'b1;
                        if (!req_we) begin
                            csb0   = 1'b0;
                            addr0  = req_addr;
                            next_s = RD_DATA;
                        end else if (mask_full_s) begin
                            csb0   = 1'b0;
                            web0   = 1'b0;
                            addr0  = req_addr;
                            din0   = req_wdata;
                            next_s = RESP;
                        end else if (mask_none_s) begin
                            next_s = RESP;
                        end else begin
                            // Partial store: fetch the old word first.
                            csb0   = 1'b0;
                            addr0  = req_addr;
                            next_s = RMW_DATA;
                        end
                    end else begin
                        next_s = IDLE;
                    end
                end
                RD_DATA:  next_s = RESP;
                RMW_DATA: next_s = RMW_WR;
                RMW_WR: begin
                    csb0   = 1'b0;
                    web0   = 1'b0;
                    addr0  = addr_r;
                    din0   = merged_r;
                    next_s = RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        next_s = IDLE;
                    end else begin
                        next_s = RESP;
                    end
                end
                default: next_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Request latch and RMW merge register.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= {ADDR_WIDTH{1'b0}};
            mask_r   <= {MASK_WIDTH{1'b0}};
            wdata_r  <= {DATA_WIDTH{1'b0}};
            merged_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                addr_r  <= req_addr;
                mask_r  <= req_mask;
                wdata_r <= req_wdata;
            end
            if (state_r == RMW_DATA) begin
                merged_r <= merged_s;
            end
        end
    end

    // Registered response channel; writes always return zero data.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rdata_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            rsp_valid_r <= (next_s == RESP);
            if (state_r == RD_DATA) begin
                rdata_r <= dout0;
            end else if (accept_s && req_we) begin
                rdata_r <= {DATA_WIDTH{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural OpenRAM macro model.
module tb_sram_ctrl;

    logic        clk0 = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_mask;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        csb0, web0;
    logic [6:0]  addr0;
    logic [31:0] din0, dout0;

    always #5 clk0 = ~clk0;

    sram_ctrl dut (
        .clk0(clk0), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    // Macro model: pins registered at posedge, write lands at negedge.
    logic [31:0] mem [128];
    logic        wr_pend;
    logic [6:0]  wr_addr;
    logic [31:0] wr_din;
    int          cyc = 0, rd_cnt = 0, wr_cnt = 0;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        wr_pend = 1'b0;
        dout0   = 32'hBAD0_BAD0;
    end

    always @(posedge clk0) begin
        cyc     <= cyc + 1;
        wr_pend <= !csb0 && !web0;
        wr_addr <= addr0;
        wr_din  <= din0;
        if (!csb0 && web0) dout0 <= mem[addr0];
        else               dout0 <= 32'hBAD0_BAD0;
        if (!csb0 && web0)  rd_cnt <= rd_cnt + 1;
        if (!csb0 && !web0) wr_cnt <= wr_cnt + 1;
    end

    always @(negedge clk0) begin
        if (wr_pend) mem[wr_addr] <= wr_din;
    end

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compares every response cycle against the head of the scoreboard.
    initial begin
        bit started;
        started = 1'b0;
        forever begin
            @(negedge clk0);
            #2;
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("rsp_without_req", {31'b0, rsp_valid}, 32'h0);
                end else begin
                    if (!started) begin
                        check("latency", cyc - sb_q[0].acc, sb_q[0].lat);
                        started = 1'b1;
                    end
                    check("rsp_rdata", rsp_rdata, sb_q[0].rdata);
                    check("req_ready_in_resp", {31'b0, req_ready}, 32'h0);
                    check("csb0_in_resp", {31'b0, csb0}, 32'h1);
                    if (rsp_ready) begin
                        void'(sb_q.pop_front());
                        started = 1'b0;
                    end
                end
            end
        end
    end

    // Call right after a negedge; returns 1 time unit after the acceptance edge.
    task automatic issue(input logic we, input logic [3:0] mask, input logic [6:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input int lat);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_mask  = mask;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        while (!req_ready && waited < 50) begin
            @(negedge clk0);
            #1;
            waited++;
        end
        if (!req_ready) check("req_ready_timeout", {31'b0, req_ready}, 32'h1);
        sb_q.push_back('{exp_rdata, lat, cyc});
        @(posedge clk0);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_mask  = 4'h0;
        req_addr  = 7'h0;
        req_wdata = 32'h0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk0);
            n++;
        end while (sb_q.size() != 0 && n < 50);
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 32'h0);
            sb_q.delete();
        end
    endtask

    initial begin
        int a0, w0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_mask  = 4'hF;
        req_addr  = 7'd9;
        req_wdata = 32'h1122_3344;
        repeat (3) @(negedge clk0);
        #1;
        check("rst_csb0", {31'b0, csb0}, 32'h1);
        check("rst_web0", {31'b0, web0}, 32'h1);
        check("rst_addr0", {25'b0, addr0}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_access", rd_cnt + wr_cnt, 32'h0);
        @(negedge clk0);
        rst_n = 1'b1;
        issue(1'b1, 4'hF, 7'd9, 32'h1122_3344, 32'h0, 1);
        drain();

        // Full write then read back.
        issue(1'b1, 4'hF, 7'd5, 32'hDEAD_BEEF, 32'h0, 1);
        drain();
        issue(1'b0, 4'h0, 7'd5, 32'h0, 32'hDEAD_BEEF, 2);
        drain();

        // Partial-mask store via read-modify-write.
        a0 = rd_cnt;
        w0 = wr_cnt;
        issue(1'b1, 4'b0101, 7'd9, 32'hAABB_CCDD, 32'h0, 3);
        drain();
        check("rmw_reads", rd_cnt - a0, 32'h1);
        check("rmw_writes", wr_cnt - w0, 32'h1);
        issue(1'b0, 4'h0, 7'd9, 32'h0, 32'h11BB_33DD, 2);
        drain();

        // Empty-mask store touches nothing.
        issue(1'b1, 4'hF, 7'd3, 32'hCAFE_F00D, 32'h0, 1);
        drain();
        a0 = rd_cnt + wr_cnt;
        issue(1'b1, 4'h0, 7'd3, 32'h1234_5678, 32'h0, 1);
        drain();
        check("zero_mask_access", rd_cnt + wr_cnt - a0, 32'h0);
        issue(1'b0, 4'h0, 7'd3, 32'h0, 32'hCAFE_F00D, 2);
        drain();

        // Response back-pressure.
        rsp_ready = 1'b0;
        issue(1'b0, 4'h0, 7'd5, 32'h0, 32'hDEAD_BEEF, 2);
        repeat (2) @(negedge clk0);
        a0 = rd_cnt + wr_cnt;
        repeat (5) @(negedge clk0);
        check("stall_access", rd_cnt + wr_cnt - a0, 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk0);
        #1;
        check("req_ready_after_hs", {31'b0, req_ready}, 32'h1);
        check("rsp_valid_after_hs", {31'b0, rsp_valid}, 32'h0);
        drain();

        // Reset during RMW_DATA must leave memory untouched.
        issue(1'b1, 4'hF, 7'h7F, 32'h0102_0304, 32'h0, 1);
        drain();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_mask  = 4'b1000;
        req_addr  = 7'h7F;
        req_wdata = 32'hFF00_0000;
        #1;
        check("abort_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk0);
        #1;
        req_valid = 1'b0;
        w0 = wr_cnt;
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_csb0", {31'b0, csb0}, 32'h1);
        check("abort_web0", {31'b0, web0}, 32'h1);
        check("abort_addr0", {25'b0, addr0}, 32'h0);
        repeat (3) @(negedge clk0);
        check("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        rst_n = 1'b1;
        issue(1'b0, 4'h0, 7'h7F, 32'h0, 32'h0102_0304, 2);
        drain();
        check("abort_writes", wr_cnt - w0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
